// File: rtl/spi_slave.sv
// SPI mode-0 target, MSB first. All pins are oversampled on CTRL_CLK; SCLK
// is only ever treated as data. One-entry TX holding register with a
// valid/ready write side; received words are emitted as RX_valid pulses.
module spi_slave #(
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  IDLE_WORD = '0
) (
    input  logic              CTRL_CLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [DATA_W-1:0] TX_data,
    input  logic              TX_valid,
    output logic              TX_ready,
    output logic [DATA_W-1:0] RX_data,
    output logic              RX_valid,
    output logic              UNDERRUN,
    output logic              ABORT
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic {IDLE, ACTIVE} state_e;

    // synchronizer chains (s1, s2) plus a history stage per pin
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic mosi_s1_q, mosi_s2_q, mosi_h_q;

    // registered edge strobes; mosi_h_q is the MOSI sample aligned to them
    logic sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                word_done_q, word_done_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                underrun_q, underrun_d;
    logic                abort_q, abort_d;
    logic                load;
    logic                tx_xfer;

    // pin synchronizers and edge strobes; all stages clear on reset so a CS
    // already low at reset release never looks like a falling edge
    always_ff @(posedge CTRL_CLK) begin
        if (RST) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_h_q    <= 1'b0;
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_h_q      <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            mosi_h_q    <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
        end else begin
            sclk_s1_q   <= SCLK;
            sclk_s2_q   <= sclk_s1_q;
            sclk_h_q    <= sclk_s2_q;
            cs_s1_q     <= CS;
            cs_s2_q     <= cs_s1_q;
            cs_h_q      <= cs_s2_q;
            mosi_s1_q   <= MOSI;
            mosi_s2_q   <= mosi_s1_q;
            mosi_h_q    <= mosi_s2_q;
            sclk_rise_q <= sclk_s2_q & ~sclk_h_q;
            sclk_fall_q <= ~sclk_s2_q & sclk_h_q;
            cs_rise_q   <= cs_s2_q & ~cs_h_q;
            cs_fall_q   <= ~cs_s2_q & cs_h_q;
        end
    end

    // state and datapath registers
    always_ff @(posedge CTRL_CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    // next-state: frame FSM, shift registers, load points and TX holder
    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = word_done_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    load        = 1'b1;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                // deselect wins over any SCLK edge seen in the same cycle
                if (cs_rise_q) begin
                    state_d     = IDLE;
                    abort_d     = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                end else if (sclk_rise_q) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_h_q};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d   = {rx_shift_q[DATA_W-2:0], mosi_h_q};
                        rx_valid_d  = 1'b1;
                        bit_cnt_d   = '0;
                        word_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall_q) begin
                    // the fall after a word's last bit starts the next word
                    if (word_done_q) begin
                        load        = 1'b1;
                        word_done_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (hold_full_q) begin
                tx_shift_d = hold_q;
            end else begin
                tx_shift_d = IDLE_WORD;
                underrun_d = 1'b1;
            end
        end

        // a write landing with a load on an empty holder fills it for the
        // following word; the current load has already taken IDLE_WORD
        tx_xfer     = TX_valid & ~hold_full_q;
        hold_d      = tx_xfer ? TX_data : hold_q;
        hold_full_d = tx_xfer ? 1'b1 : (load ? 1'b0 : hold_full_q);
    end

    assign MISO     = (state_q == ACTIVE) & tx_shift_q[DATA_W-1];
    assign MISO_OE  = (state_q == ACTIVE);
    assign TX_ready = ~hold_full_q;
    assign RX_data  = rx_data_q;
    assign RX_valid = rx_valid_q;
    assign UNDERRUN = underrun_q;
    assign ABORT    = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural mode-0 master drives the pins, a
// scoreboard queue holds the words the DUT must report on RX_valid.
module tb_spi_slave;

    localparam int HALF = 8;   // CTRL_CLK cycles per SCLK half period

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       SCLK = 1'b0;
    logic       CS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO, MISO_OE, TX_ready, RX_valid, UNDERRUN, ABORT;
    logic [7:0] TX_data = 8'h00;
    logic       TX_valid = 1'b0;
    logic [7:0] RX_data;

    int checks = 0;
    int errors = 0;
    int cnt_rxv = 0;
    int cnt_unr = 0;
    int cnt_abort = 0;
    logic [7:0] rx_q[$];
    logic [7:0] last_rx = 8'h00;

    spi_slave #(.DATA_W(8), .IDLE_WORD(8'h00)) dut (
        .CTRL_CLK(clk), .RST(RST), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .TX_data(TX_data), .TX_valid(TX_valid),
        .TX_ready(TX_ready), .RX_data(RX_data), .RX_valid(RX_valid),
        .UNDERRUN(UNDERRUN), .ABORT(ABORT)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard side: every RX_valid pulse consumes one expected word
    always @(negedge clk) begin
        if (RX_valid) begin
            cnt_rxv++;
            if (rx_q.size() == 0) begin
                chk("rx_unexpected", {24'h0, RX_data}, 32'hFFFF_FFFF);
            end else begin
                chk("rx_data", {24'h0, RX_data}, {24'h0, rx_q.pop_front()});
            end
        end
        if (UNDERRUN) cnt_unr++;
        if (ABORT) cnt_abort++;
    end

    task automatic tx_write(input logic [7:0] d);
        bit got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (TX_ready) got = 1;
            else wait_clks(1);
        end
        chk("tx_ready_wait", {31'h0, got}, 32'h1);
        TX_data  = d;
        TX_valid = 1'b1;
        wait_clks(1);
        TX_valid = 1'b0;
        chk("tx_ready_fall", {31'h0, TX_ready}, 32'h0);
    endtask

    // mode-0 master; end_cs raises CS together with the last SCLK fall
    task automatic spi_frame(input int nbits, input logic [15:0] mosi, input int wr_bit,
                             input logic [7:0] wr_data, input bit end_cs,
                             output logic [15:0] miso_o);
        miso_o = '0;
        CS = 1'b0;
        wait_clks(HALF);
        chk("miso_oe_active", {31'h0, MISO_OE}, 32'h1);
        for (int b = 0; b < nbits; b++) begin
            MOSI = mosi[nbits-1-b];
            if (b == wr_bit) begin
                TX_data  = wr_data;
                TX_valid = 1'b1;
                wait_clks(1);
                TX_valid = 1'b0;
                wait_clks(HALF - 1);
            end else begin
                wait_clks(HALF);
            end
            miso_o = {miso_o[14:0], MISO};
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
            if (b == nbits - 1 && end_cs) CS = 1'b1;
        end
        if (end_cs) begin
            wait_clks(HALF);
            chk("miso_oe_idle", {31'h0, MISO_OE}, 32'h0);
        end
    endtask

    typedef struct {
        bit         load_tx;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        int         exp_unr;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [15:0] m, m2;
        int u0, r0, a0;
        bit got;

        vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
        vt[1] = '{1'b0, 8'h00, 8'h5A, 8'h00, 1};
        vt[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 0};
        vt[3] = '{1'b1, 8'h01, 8'hFF, 8'h01, 0};
        vt[4] = '{1'b1, 8'hC3, 8'h81, 8'hC3, 0};
        vt[5] = '{1'b0, 8'h00, 8'hE7, 8'h00, 1};

        // reset state
        wait_clks(4);
        chk("rst_miso", {31'h0, MISO}, 32'h0);
        chk("rst_miso_oe", {31'h0, MISO_OE}, 32'h0);
        chk("rst_tx_ready", {31'h0, TX_ready}, 32'h1);
        chk("rst_rx_data", {24'h0, RX_data}, 32'h0);
        chk("rst_rx_valid", {31'h0, RX_valid}, 32'h0);
        chk("rst_underrun", {31'h0, UNDERRUN}, 32'h0);
        chk("rst_abort", {31'h0, ABORT}, 32'h0);
        RST = 1'b0;
        wait_clks(10);

        // single-word frames, with and without a held TX word
        for (int i = 0; i < 6; i++) begin
            if (vt[i].load_tx) tx_write(vt[i].tx);
            u0 = cnt_unr;
            r0 = cnt_rxv;
            rx_q.push_back(vt[i].mosi);
            last_rx = vt[i].mosi;
            spi_frame(8, {8'h00, vt[i].mosi}, -1, 8'h00, 1'b1, m);
            chk("vec_miso", {16'h0, m}, {24'h0, vt[i].exp_miso});
            wait_clks(10);
            chk("vec_underrun", u0 + vt[i].exp_unr, cnt_unr);
            chk("vec_rx_pulses", r0 + 1, cnt_rxv);
            chk("vec_tx_ready", {31'h0, TX_ready}, 32'h1);
        end

        // continuous two-word frame, second TX word written during bit 3
        tx_write(8'h81);
        u0 = cnt_unr;
        r0 = cnt_rxv;
        rx_q.push_back(8'h12);
        rx_q.push_back(8'h34);
        last_rx = 8'h34;
        spi_frame(16, 16'h1234, 3, 8'h7E, 1'b1, m);
        chk("cont_miso", {16'h0, m}, 32'h817E);
        wait_clks(10);
        chk("cont_underrun", u0, cnt_unr);
        chk("cont_rx_pulses", r0 + 2, cnt_rxv);

        // abort after five bits, then a clean frame
        a0 = cnt_abort;
        r0 = cnt_rxv;
        spi_frame(5, 16'h001F, -1, 8'h00, 1'b1, m);
        wait_clks(10);
        chk("abort_pulse", a0 + 1, cnt_abort);
        chk("abort_no_rx", r0, cnt_rxv);
        chk("abort_rx_hold", {24'h0, RX_data}, {24'h0, last_rx});
        rx_q.push_back(8'h55);
        last_rx = 8'h55;
        spi_frame(8, 16'h0055, -1, 8'h00, 1'b1, m);
        wait_clks(10);
        chk("post_abort_rx", r0 + 1, cnt_rxv);
        chk("post_abort_no_abort", a0 + 1, cnt_abort);

        // back-to-back handshake with TX_valid held high
        TX_data  = 8'h11;
        TX_valid = 1'b1;
        wait_clks(1);
        TX_data = 8'h22;
        wait_clks(3);
        chk("b2b_ready_low", {31'h0, TX_ready}, 32'h0);
        u0 = cnt_unr;
        rx_q.push_back(8'h99);
        rx_q.push_back(8'h66);
        last_rx = 8'h66;
        fork
            spi_frame(8, 16'h0099, -1, 8'h00, 1'b1, m);
            begin
                got = 0;
                for (int k = 0; k < 300 && !got; k++) begin
                    wait_clks(1);
                    if (TX_ready) got = 1;
                end
                chk("b2b_ready_rise", {31'h0, got}, 32'h1);
                wait_clks(1);
                TX_valid = 1'b0;
                chk("b2b_second_accept", {31'h0, TX_ready}, 32'h0);
            end
        join
        chk("b2b_miso1", {16'h0, m}, 32'h11);
        wait_clks(5);
        spi_frame(8, 16'h0066, -1, 8'h00, 1'b1, m2);
        chk("b2b_miso2", {16'h0, m2}, 32'h22);
        wait_clks(10);
        chk("b2b_underrun", u0, cnt_unr);
        chk("b2b_tx_ready", {31'h0, TX_ready}, 32'h1);

        // reset mid-frame with CS held low
        a0 = cnt_abort;
        r0 = cnt_rxv;
        spi_frame(3, 16'h0005, -1, 8'h00, 1'b0, m);
        wait_clks(2);
        RST = 1'b1;
        wait_clks(1);
        RST = 1'b0;
        chk("mrst_miso", {31'h0, MISO}, 32'h0);
        chk("mrst_miso_oe", {31'h0, MISO_OE}, 32'h0);
        chk("mrst_tx_ready", {31'h0, TX_ready}, 32'h1);
        chk("mrst_rx_data", {24'h0, RX_data}, 32'h0);
        chk("mrst_rx_valid", {31'h0, RX_valid}, 32'h0);
        chk("mrst_underrun", {31'h0, UNDERRUN}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
            wait_clks(HALF);
            chk("mrst_stays_idle", {31'h0, MISO_OE}, 32'h0);
        end
        chk("mrst_no_abort", a0, cnt_abort);
        chk("mrst_no_rx", r0, cnt_rxv);
        CS = 1'b1;
        wait_clks(10);
        rx_q.push_back(8'hC3);
        last_rx = 8'hC3;
        spi_frame(8, 16'h00C3, -1, 8'h00, 1'b1, m);
        chk("mrst_frame_miso", {16'h0, m}, 32'h00);
        wait_clks(10);
        chk("mrst_frame_rx", r0 + 1, cnt_rxv);
        chk("mrst_rx_last", {24'h0, RX_data}, 32'hC3);

        chk("scoreboard_empty", rx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
